bm_dag_pipe_param: RTL and testbench

- Parametrised successor to the fixed 2-bit DAG microbenchmarks.
- Two operands pass through a DEPTH-stage register DAG and then a mode-selected combine stage (AND/OR/XOR/ADD with carry).
- Adds valid tracking, a global stall, and a saturating output counter.
- Stress benchmark for synthesis of parametrised pipelines, async reset and enables.

---
 rtl/bm_dag_pipe_param.sv | 137 +++++++++++++
 tb/tb_bm_dag_pipe_param.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bm_dag_pipe_param.sv
`default_nettype none
// ============================================================================
// Module   : bm_dag_pipe_param
// Brief    : two-operand register DAG of DEPTH stages feeding a mode-selected
//            combine stage, with valid tracking, global stall and a
//            saturating result counter
// Revision : 1.0
// ============================================================================
module bm_dag_pipe_param #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 3,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] first,
    input  logic [WIDTH-1:0] second,
    input  logic [1:0]       mode,
    input  logic             stall,
    input  logic             clr,
    output logic             out_valid,
    output logic [WIDTH-1:0] out0,
    output logic             out1,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [1:0] MODE_AND = 2'b00;
    localparam logic [1:0] MODE_OR  = 2'b01;
    localparam logic [1:0] MODE_XOR = 2'b10;

    logic [WIDTH-1:0] x_q [1:DEPTH];
    logic [WIDTH-1:0] x_d [1:DEPTH];
    logic [WIDTH-1:0] y_q [1:DEPTH];
    logic [WIDTH-1:0] y_d [1:DEPTH];
    logic [1:0]       m_q [1:DEPTH];
    logic [1:0]       m_d [1:DEPTH];
    logic             v_q [1:DEPTH];
    logic             v_d [1:DEPTH];

    logic [WIDTH-1:0] out0_q, out0_d;
    logic             out1_q, out1_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic [WIDTH:0]   sum_w;

    assign sum_w = {1'b0, x_q[DEPTH]} + {1'b0, y_q[DEPTH]};

    // Data stages load on every non-stalled cycle regardless of valid.
    always_comb begin
        for (int k = 1; k <= DEPTH; k++) begin
            x_d[k] = x_q[k];
            y_d[k] = y_q[k];
            m_d[k] = m_q[k];
            v_d[k] = v_q[k];
        end
        if (!stall) begin
            x_d[1] = first ^ second;
            y_d[1] = first & second;
            m_d[1] = mode;
            v_d[1] = in_valid;
            for (int k = 2; k <= DEPTH; k++) begin
                x_d[k] = x_q[k-1] | y_q[k-1];
                y_d[k] = y_q[k-1];
                m_d[k] = m_q[k-1];
                v_d[k] = v_q[k-1];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out0_d      = out0_q;
        out1_d      = out1_q;
        out_count_d = out_count_q;
        if (!stall) begin
            out_valid_d = v_q[DEPTH];
            if (v_q[DEPTH]) begin
                case (m_q[DEPTH])
                    MODE_AND: begin
                        out0_d = x_q[DEPTH] & y_q[DEPTH];
                        out1_d = 1'b0;
                    end
                    MODE_OR: begin
                        out0_d = x_q[DEPTH] | y_q[DEPTH];
                        out1_d = 1'b0;
                    end
                    MODE_XOR: begin
                        out0_d = x_q[DEPTH] ^ y_q[DEPTH];
                        out1_d = 1'b0;
                    end
                    default: begin
                        out0_d = sum_w[WIDTH-1:0];
                        out1_d = sum_w[WIDTH];
                    end
                endcase
            end
            // Clear wins over a result completing in the same cycle.
            if (clr) begin
                out_count_d = '0;
            end else if (v_q[DEPTH] && (out_count_q != {CNT_W{1'b1}})) begin
                out_count_d = out_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 1; k <= DEPTH; k++) begin
                x_q[k] <= '0;
                y_q[k] <= '0;
                m_q[k] <= '0;
                v_q[k] <= 1'b0;
            end
            out0_q      <= '0;
            out1_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            m_q         <= m_d;
            v_q         <= v_d;
            out0_q      <= out0_d;
            out1_q      <= out1_d;
            out_valid_q <= out_valid_d;
            out_count_q <= out_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out0      = out0_q;
    assign out1      = out1_q;
    assign out_count = out_count_q;

endmodule
`default_nettype wire

// File: tb/tb_bm_dag_pipe_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_bm_dag_pipe_param
// Brief    : scoreboard bench for bm_dag_pipe_param (default and 3-bit counter)
// Revision : 1.0
// ============================================================================
module tb_bm_dag_pipe_param;

    localparam int WIDTH = 4;
    localparam int DEPTH = 3;
    localparam int CNT_W = 8;
    localparam int SAT_W = 3;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic [WIDTH-1:0] first, second;
    logic [1:0]       mode;
    logic             stall, clr;
    logic             out_valid, sat_out_valid;
    logic [WIDTH-1:0] out0, sat_out0;
    logic             out1, sat_out1;
    logic [CNT_W-1:0] out_count;
    logic [SAT_W-1:0] sat_out_count;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int             due;
        logic [WIDTH:0] res;
    } exp_t;
    exp_t sb_q[$];

    int               tick = 0;
    int               cnt_m = 0;
    int               sat_m = 0;
    logic             e_rn, e_st, e_iv, e_clr, exp_v;
    logic [WIDTH-1:0] e_a, e_b;
    logic [1:0]       e_md;
    exp_t             r;
    logic             prev_v;
    logic [WIDTH-1:0] prev_o0;
    logic             prev_o1;
    logic [CNT_W-1:0] prev_cnt;
    logic [SAT_W-1:0] prev_sat;

    bm_dag_pipe_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid),
        .first(first), .second(second), .mode(mode), .stall(stall), .clr(clr),
        .out_valid(out_valid), .out0(out0), .out1(out1), .out_count(out_count)
    );

    bm_dag_pipe_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(SAT_W)) u_sat (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid),
        .first(first), .second(second), .mode(mode), .stall(stall), .clr(clr),
        .out_valid(sat_out_valid), .out0(sat_out0), .out1(sat_out1),
        .out_count(sat_out_count)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_vec++;
        if (obs !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, req, $time);
        end
    endtask

    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic [1:0] md);
        case (md)
            2'b00:   return {1'b0, a & b};
            2'b01:   return {1'b0, a | b};
            2'b10:   return {1'b0, a ^ b};
            default: return {1'b0, a} + {1'b0, b};
        endcase
    endfunction

    task automatic clear_model();
        sb_q.delete();
        cnt_m    = 0;
        sat_m    = 0;
        prev_v   = 1'b0;
        prev_o0  = '0;
        prev_o1  = 1'b0;
        prev_cnt = '0;
        prev_sat = '0;
    endtask

    always @(negedge reset_n) clear_model();

    // Monitor: inputs are stable at the edge; outputs are sampled 1ns later.
    always @(posedge clock) begin
        e_rn  = reset_n;
        e_st  = stall;
        e_iv  = in_valid;
        e_clr = clr;
        e_a   = first;
        e_b   = second;
        e_md  = mode;
        #1;
        if (!e_rn) begin
            clear_model();
            check_eq("rst_out_valid", {31'd0, out_valid}, 0);
            check_eq("rst_out0", {28'd0, out0}, 0);
            check_eq("rst_out1", {31'd0, out1}, 0);
            check_eq("rst_out_count", {24'd0, out_count}, 0);
            check_eq("rst_sat_count", {29'd0, sat_out_count}, 0);
        end else if (e_st) begin
            check_eq("stall_out_valid", {31'd0, out_valid}, {31'd0, prev_v});
            check_eq("stall_out0", {28'd0, out0}, {28'd0, prev_o0});
            check_eq("stall_out1", {31'd0, out1}, {31'd0, prev_o1});
            check_eq("stall_out_count", {24'd0, out_count}, {24'd0, prev_cnt});
            check_eq("stall_sat_count", {29'd0, sat_out_count}, {29'd0, prev_sat});
        end else begin
            tick++;
            exp_v = (sb_q.size() > 0) && (sb_q[0].due == tick);
            check_eq("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
            check_eq("sat_out_valid", {31'd0, sat_out_valid}, {31'd0, exp_v});
            if (exp_v) begin
                r = sb_q.pop_front();
                check_eq("out0", {28'd0, out0}, {28'd0, r.res[WIDTH-1:0]});
                check_eq("out1", {31'd0, out1}, {31'd0, r.res[WIDTH]});
            end
            if (e_clr) begin
                cnt_m = 0;
                sat_m = 0;
            end else if (exp_v) begin
                if (cnt_m < (1 << CNT_W) - 1) cnt_m++;
                if (sat_m < (1 << SAT_W) - 1) sat_m++;
            end
            check_eq("out_count", {24'd0, out_count}, cnt_m);
            check_eq("sat_count", {29'd0, sat_out_count}, sat_m);
            if (e_iv) sb_q.push_back('{due: tick + DEPTH, res: model(e_a, e_b, e_md)});
        end
        prev_v   = out_valid;
        prev_o0  = out0;
        prev_o1  = out1;
        prev_cnt = out_count;
        prev_sat = sat_out_count;
    end

    task automatic drive(input logic iv, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [1:0] md, input logic st, input logic cl);
        @(negedge clock);
        in_valid = iv;
        first    = a;
        second   = b;
        mode     = md;
        stall    = st;
        clr      = cl;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 2'b00, 1'b0, 1'b0);
    endtask

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        first    = '0;
        second   = '0;
        mode     = '0;
        stall    = 1'b0;
        clr      = 1'b0;

        // Reset held with inputs toggling
        for (int i = 0; i < 5; i++)
            drive(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 2'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        @(negedge clock);
        in_valid = 1'b0; stall = 1'b0; clr = 1'b0;
        reset_n  = 1'b1;
        idle(5);

        // Single ADD sample: A + 6 = 0x10
        drive(1'b1, 4'hA, 4'h6, 2'b11, 1'b0, 1'b0);
        idle(7);

        // Back-to-back, all four modes
        for (int m = 0; m < 4; m++) drive(1'b1, 4'hA, 4'h6, 2'(m), 1'b0, 1'b0);
        idle(7);

        // Two-cycle stall with a sample mid-pipe
        drive(1'b1, 4'h3, 4'h5, 2'b11, 1'b0, 1'b0);
        drive(1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0);
        drive(1'b1, 4'hF, 4'hF, 2'b11, 1'b1, 1'b0);
        drive(1'b1, 4'hF, 4'hF, 2'b11, 1'b1, 1'b0);
        idle(7);

        // Saturation of the 3-bit counter, then clear
        for (int i = 0; i < 9; i++) drive(1'b1, 4'(i), 4'(15 - i), 2'(i), 1'b0, 1'b0);
        idle(6);
        check_eq("sat_at_7", {29'd0, sat_out_count}, 7);
        drive(1'b0, '0, '0, 2'b00, 1'b0, 1'b1);
        idle(2);
        check_eq("sat_cleared", {29'd0, sat_out_count}, 0);

        // Clear coinciding with a completing result
        drive(1'b1, 4'h9, 4'h9, 2'b11, 1'b0, 1'b0);
        idle(2);
        drive(1'b0, '0, '0, 2'b00, 1'b0, 1'b1);
        idle(4);

        // Random traffic with stalls and clears
        for (int i = 0; i < 200; i++)
            drive(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 2'($urandom),
                  1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 19) == 0));
        idle(2);

        // Async reset with three samples in flight
        for (int i = 0; i < 3; i++) drive(1'b1, 4'h7, 4'h2, 2'(i), 1'b0, 1'b0);
        @(negedge clock);
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("arst_out_valid", {31'd0, out_valid}, 0);
        check_eq("arst_out_count", {24'd0, out_count}, 0);
        check_eq("arst_sat_count", {29'd0, sat_out_count}, 0);
        @(negedge clock);
        reset_n = 1'b1;
        idle(8);

        check_eq("sb_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
